// File: rtl/tag_lookup_pkg.sv
// Shared definitions for the tag lookup controller: field widths, tag word
// layout, FSM state encoding and the hit-compare helper.
package tag_lookup_pkg;

   localparam int TAG_W     = 5;
   localparam int IDX_W     = 3;
   localparam int ADDR_W    = TAG_W + IDX_W;
   localparam int TAGWORD_W = 6;
   localparam int VALID_BIT = 5;
   localparam int TIMEOUT   = 15;
   localparam int CNT_W     = 4;
   localparam int STAT_W    = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      FILL  = 3'd4
   } state_t;

   // A stored word hits when its valid bit is set and its tag field matches.
   function automatic logic tag_match(input logic [TAGWORD_W-1:0] word,
                                      input logic [TAG_W-1:0]     tag);
      return word[VALID_BIT] && (word[TAG_W-1:0] == tag);
   endfunction

endpackage

// File: rtl/tag_lookup_stats.sv
// Saturating hit/miss event counters for the tag lookup controller.
// Only instantiated when TAG_LOOKUP_STATS_EN is defined.
module tag_lookup_stats
   import tag_lookup_pkg::*;
(
   input  logic              TL_clk,
   input  logic              rst,
   input  logic              inc_hit,
   input  logic              inc_miss,
   output logic [STAT_W-1:0] hit_count,
   output logic [STAT_W-1:0] miss_count
);

   // Count one event per pulse, holding at all-ones instead of wrapping.
   always_ff @(posedge TL_clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (inc_hit && (hit_count != '1))
            hit_count <= hit_count + STAT_W'(1);
         if (inc_miss && (miss_count != '1))
            miss_count <= miss_count + STAT_W'(1);
      end
   end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Tag lookup controller: serialises lookups and line fills onto a tag array
// with a handshake read port and a single-cycle write port. Every output is
// a flop loaded from the next-state logic, so no input reaches an output
// combinationally. Optional saturating hit/miss statistics are built when
// TAG_LOOKUP_STATS_EN is defined.
module tag_lookup_ctrl
   import tag_lookup_pkg::*;
(
   input  logic                 TL_clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic                 fill_valid,
   input  logic [ADDR_W-1:0]    fill_addr,
   output logic                 req_ready,
   output logic                 resp_valid,
   output logic                 resp_hit,
   output logic                 resp_err,
   output logic [IDX_W-1:0]     ta_read_select,
   output logic                 ta_read_enable,
   input  logic                 ta_finish,
   output logic [IDX_W-1:0]     ta_write_select,
   output logic [TAGWORD_W-1:0] ta_write_data,
   output logic                 ta_write_enable,
`ifdef TAG_LOOKUP_STATS_EN
   output logic [STAT_W-1:0]    hit_count,
   output logic [STAT_W-1:0]    miss_count,
`endif
   input  logic [TAGWORD_W-1:0] ta_out_data
);

   state_t                 state_q, state_n;
   logic [TAG_W-1:0]       tag_q, tag_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic                   ready_n;
   logic                   rd_en_n, wr_en_n;
   logic [IDX_W-1:0]       rd_sel_n, wr_sel_n;
   logic [TAGWORD_W-1:0]   wr_data_n;
   logic                   rsp_vld_n, rsp_hit_n, rsp_err_n;

   // Next state plus next value of every registered output; outputs belong
   // to the state being entered, so strobes are raised on the entry edge.
   always_comb begin
      state_n   = state_q;
      tag_n     = tag_q;
      cnt_n     = cnt_q;
      rd_en_n   = 1'b0;
      rd_sel_n  = ta_read_select;
      wr_en_n   = 1'b0;
      wr_sel_n  = ta_write_select;
      wr_data_n = ta_write_data;
      rsp_vld_n = 1'b0;
      rsp_hit_n = resp_hit;
      rsp_err_n = resp_err;
      case (state_q)
         IDLE: begin
            if (fill_valid) begin
               state_n   = FILL;
               wr_en_n   = 1'b1;
               wr_sel_n  = fill_addr[IDX_W-1:0];
               wr_data_n = {1'b1, fill_addr[ADDR_W-1:IDX_W]};
            end else if (req_valid) begin
               state_n  = ISSUE;
               tag_n    = req_addr[ADDR_W-1:IDX_W];
               rd_en_n  = 1'b1;
               rd_sel_n = req_addr[IDX_W-1:0];
               cnt_n    = '0;
            end
         end
         ISSUE: begin
            state_n = WAIT;
            cnt_n   = '0;
         end
         WAIT: begin
            if (ta_finish) begin
               state_n   = RESP;
               rsp_vld_n = 1'b1;
               rsp_hit_n = tag_match(ta_out_data, tag_q);
               rsp_err_n = 1'b0;
            end else begin
               cnt_n = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_n   = RESP;
                  rsp_vld_n = 1'b1;
                  rsp_hit_n = 1'b0;
                  rsp_err_n = 1'b1;
               end
            end
         end
         RESP:    state_n = IDLE;
         FILL:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      ready_n = (state_n == IDLE);
   end

   // State, latched lookup tag, timeout counter and all output flops.
   always_ff @(posedge TL_clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         tag_q           <= '0;
         cnt_q           <= '0;
         req_ready       <= 1'b1;
         ta_read_enable  <= 1'b0;
         ta_read_select  <= '0;
         ta_write_enable <= 1'b0;
         ta_write_select <= '0;
         ta_write_data   <= '0;
         resp_valid      <= 1'b0;
         resp_hit        <= 1'b0;
         resp_err        <= 1'b0;
      end else begin
         state_q         <= state_n;
         tag_q           <= tag_n;
         cnt_q           <= cnt_n;
         req_ready       <= ready_n;
         ta_read_enable  <= rd_en_n;
         ta_read_select  <= rd_sel_n;
         ta_write_enable <= wr_en_n;
         ta_write_select <= wr_sel_n;
         ta_write_data   <= wr_data_n;
         resp_valid      <= rsp_vld_n;
         resp_hit        <= rsp_hit_n;
         resp_err        <= rsp_err_n;
      end
   end

`ifdef TAG_LOOKUP_STATS_EN
   tag_lookup_stats u_stats (
      .TL_clk     (TL_clk),
      .rst        (rst),
      .inc_hit    (resp_valid & resp_hit),
      .inc_miss   (resp_valid & ~resp_hit),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Testbench for tag_lookup_ctrl with a behavioural tag array (one-cycle
// read latency, optional withheld finish) and a response scoreboard.
// Stats checks are compiled only when TAG_LOOKUP_STATS_EN is defined.
module tb_tag_lookup_ctrl;

   logic       TL_clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic [7:0] req_addr = '0;
   logic       fill_valid = 1'b0;
   logic [7:0] fill_addr = '0;
   logic       req_ready, resp_valid, resp_hit, resp_err;
   logic [2:0] ta_read_select, ta_write_select;
   logic       ta_read_enable, ta_write_enable;
   logic [5:0] ta_write_data;
   logic       ta_finish;
   logic [5:0] ta_out_data;
`ifdef TAG_LOOKUP_STATS_EN
   logic [15:0] hit_count, miss_count;
`endif

   tag_lookup_ctrl dut (
      .TL_clk          (TL_clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .fill_valid      (fill_valid),
      .fill_addr       (fill_addr),
      .req_ready       (req_ready),
      .resp_valid      (resp_valid),
      .resp_hit        (resp_hit),
      .resp_err        (resp_err),
      .ta_read_select  (ta_read_select),
      .ta_read_enable  (ta_read_enable),
      .ta_finish       (ta_finish),
      .ta_write_select (ta_write_select),
      .ta_write_data   (ta_write_data),
      .ta_write_enable (ta_write_enable),
`ifdef TAG_LOOKUP_STATS_EN
      .hit_count       (hit_count),
      .miss_count      (miss_count),
`endif
      .ta_out_data     (ta_out_data)
   );

   always #5 TL_clk = ~TL_clk;

   typedef struct packed {
      logic       got;
      logic       hit;
      logic       err;
      logic [7:0] lat;
   } rsp_t;

   rsp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   // Idle-state vector {req_ready, resp_valid, resp_hit, resp_err, rd_en,
   // rd_sel, wr_en, wr_sel, wr_data} expected while/after reset.
   logic [17:0] idle_vec = 18'h20000;

   always @(posedge TL_clk) cyc <= cyc + 1;

   // Tag array model: writes on the strobe edge, read data and finish one
   // cycle after the read strobe unless withheld.
   logic [5:0] mem [8];
   logic       withhold = 1'b0;
   logic       force_fin = 1'b0;
   logic       model_fin;

   always @(posedge TL_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
         model_fin   <= 1'b0;
         ta_out_data <= '0;
      end else begin
         if (ta_write_enable) mem[ta_write_select] <= ta_write_data;
         model_fin <= ta_read_enable && !withhold;
         if (ta_read_enable) ta_out_data <= mem[ta_read_select];
      end
   end

   assign ta_finish = model_fin | force_fin;

   task automatic wait_ready(output logic ok);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (req_ready === 1'b1) begin
            ok = 1'b1;
            return;
         end
         @(negedge TL_clk);
      end
   endtask

   task automatic send_req(input logic [7:0] a, output logic [3:0] rd_obs, output logic ok);
      wait_ready(ok);
      rd_obs = '0;
      if (!ok) return;
      req_addr  = a;
      req_valid = 1'b1;
      @(posedge TL_clk);
      #1;
      acc_cyc   = cyc;
      rd_obs    = {ta_read_enable, ta_read_select};
      req_valid = 1'b0;
   endtask

   task automatic send_fill(input logic [7:0] a, output logic [9:0] wr_obs, output logic ok);
      wait_ready(ok);
      wr_obs = '0;
      if (!ok) return;
      fill_addr  = a;
      fill_valid = 1'b1;
      @(posedge TL_clk);
      #1;
      acc_cyc    = cyc;
      wr_obs     = {ta_write_enable, ta_write_select, ta_write_data};
      fill_valid = 1'b0;
   endtask

   task automatic get_resp(output rsp_t r);
      r = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge TL_clk);
         if (resp_valid === 1'b1) begin
            r.got = 1'b1;
            r.hit = resp_hit;
            r.err = resp_err;
            r.lat = 8'(cyc - acc_cyc);
            return;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      rst = 1'b1;
      #2;
      n_cmp++;
      if ({req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
           ta_write_enable, ta_write_select, ta_write_data} !== idle_vec) begin
         n_bad++;
         $display("FAIL reset_outputs: got %b, expected %b",
                  {req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
                   ta_write_enable, ta_write_select, ta_write_data}, idle_vec);
      end
      @(negedge TL_clk);
      @(negedge TL_clk);
      rst = 1'b0;
   endtask

   task automatic test_miss_after_reset();
      logic [3:0] rd;
      logic       ok;
      rsp_t       ex, r;
      sb.push_back({1'b1, 1'b0, 1'b0, 8'd2});
      send_req(8'hA5, rd, ok);
      n_cmp++;
      if (!ok || rd !== 4'b1101) begin
         n_bad++;
         $display("FAIL issue_a5: ok=%0b rd_en/sel=%b, expected 1101", ok, rd);
      end
      @(posedge TL_clk);
      #1;
      n_cmp++;
      if (ta_read_enable !== 1'b0) begin
         n_bad++;
         $display("FAIL read_strobe_width: rd_en=%b in WAIT, expected 0", ta_read_enable);
      end
      get_resp(r);
      ex = sb.pop_front();
      n_cmp++;
      if (r !== ex) begin
         n_bad++;
         $display("FAIL lookup_a5_miss: got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                  r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
      end
      @(negedge TL_clk);
      n_cmp++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL resp_to_idle: ready=%b resp_valid=%b, expected 1/0", req_ready, resp_valid);
      end
   endtask

   task automatic test_fill_hit();
      logic [9:0] wr;
      logic [3:0] rd;
      logic       ok;
      rsp_t       ex, r;
      send_fill(8'hA5, wr, ok);
      n_cmp++;
      if (!ok || wr !== {1'b1, 3'd5, 6'h34}) begin
         n_bad++;
         $display("FAIL fill_a5_write: ok=%0b en/sel/data=%h, expected %h", ok, wr, {1'b1, 3'd5, 6'h34});
      end
      @(posedge TL_clk);
      #1;
      n_cmp++;
      if (ta_write_enable !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL fill_one_cycle: wr_en=%b ready=%b, expected 0/1", ta_write_enable, req_ready);
      end
      sb.push_back({1'b1, 1'b1, 1'b0, 8'd2});
      sb.push_back({1'b1, 1'b0, 1'b0, 8'd2});
      for (int i = 0; i < 2; i++) begin
         send_req((i == 0) ? 8'hA5 : 8'hAD, rd, ok);
         get_resp(r);
         ex = sb.pop_front();
         n_cmp++;
         if (!ok || r !== ex) begin
            n_bad++;
            $display("FAIL lookup_after_fill_%0d: got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                     i, r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
         end
      end
   endtask

   task automatic test_priority();
      logic ok;
      logic seen;
      rsp_t ex, r;
      wait_ready(ok);
      req_addr   = 8'h3B;
      fill_addr  = 8'h3B;
      req_valid  = 1'b1;
      fill_valid = 1'b1;
      sb.push_back({1'b1, 1'b1, 1'b0, 8'd4});
      @(posedge TL_clk);
      #1;
      acc_cyc    = cyc;
      fill_valid = 1'b0;
      n_cmp++;
      if ({ta_write_enable, ta_read_enable, req_ready} !== 3'b100) begin
         n_bad++;
         $display("FAIL fill_priority: wr_en/rd_en/ready=%b, expected 100",
                  {ta_write_enable, ta_read_enable, req_ready});
      end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(posedge TL_clk);
         #1;
         seen = (ta_read_enable === 1'b1);
      end
      req_valid = 1'b0;
      get_resp(r);
      ex = sb.pop_front();
      n_cmp++;
      if (!seen || r !== ex) begin
         n_bad++;
         $display("FAIL pending_req_after_fill: issued=%0b got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                  seen, r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] rd;
      logic       ok;
      rsp_t       ex, r;
      withhold = 1'b1;
      sb.push_back({1'b1, 1'b0, 1'b1, 8'd16});
      send_req(8'h11, rd, ok);
      get_resp(r);
      ex = sb.pop_front();
      n_cmp++;
      if (!ok || r !== ex) begin
         n_bad++;
         $display("FAIL timeout_err: got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                  r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
      end
      @(negedge TL_clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_ready: ready=%b, expected 1", req_ready);
      end
      withhold = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      logic [3:0] rd;
      logic [9:0] wr;
      logic       ok;
      int         pulses;
      rsp_t       ex, r;
      withhold = 1'b1;
      send_req(8'h22, rd, ok);
      repeat (3) @(posedge TL_clk);
      @(negedge TL_clk);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
           ta_write_enable, ta_write_select, ta_write_data} !== idle_vec) begin
         n_bad++;
         $display("FAIL reset_mid_wait: got %b, expected %b",
                  {req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
                   ta_write_enable, ta_write_select, ta_write_data}, idle_vec);
      end
      @(negedge TL_clk);
      rst       = 1'b0;
      withhold  = 1'b0;
      force_fin = 1'b1;
      @(negedge TL_clk);
      force_fin = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         if (resp_valid === 1'b1) pulses++;
         @(negedge TL_clk);
      end
      n_cmp++;
      if (pulses != 0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL late_finish_ignored: resp pulses=%0d ready=%b, expected 0/1", pulses, req_ready);
      end
      send_fill(8'hFF, wr, ok);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
           ta_write_enable, ta_write_select, ta_write_data} !== idle_vec) begin
         n_bad++;
         $display("FAIL reset_mid_fill: got %b, expected %b",
                  {req_ready, resp_valid, resp_hit, resp_err, ta_read_enable, ta_read_select,
                   ta_write_enable, ta_write_select, ta_write_data}, idle_vec);
      end
      @(negedge TL_clk);
      rst = 1'b0;
      sb.push_back({1'b1, 1'b0, 1'b0, 8'd2});
      send_req(8'hFF, rd, ok);
      get_resp(r);
      ex = sb.pop_front();
      n_cmp++;
      if (!ok || r !== ex) begin
         n_bad++;
         $display("FAIL aborted_fill_miss: got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                  r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] fills [2] = '{8'h08, 8'hF7};
      logic [7:0] looks [5] = '{8'h08, 8'hF7, 8'h0F, 8'h10, 8'h08};
      logic       hits  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [9:0] wr;
      logic [3:0] rd;
      logic       ok;
      rsp_t       ex, r;
      @(negedge TL_clk);
      #2;
      rst = 1'b1;
      @(negedge TL_clk);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) send_fill(fills[i], wr, ok);
      for (int i = 0; i < 5; i++) sb.push_back({1'b1, hits[i], 1'b0, 8'd2});
      for (int i = 0; i < 5; i++) begin
         send_req(looks[i], rd, ok);
         get_resp(r);
         ex = sb.pop_front();
         n_cmp++;
         if (!ok || r !== ex) begin
            n_bad++;
            $display("FAIL b2b_lookup_%0d_%h: got=%0b hit=%0b err=%0b lat=%0d, expected hit=%0b err=%0b lat=%0d",
                     i, looks[i], r.got, r.hit, r.err, r.lat, ex.hit, ex.err, ex.lat);
         end
      end
`ifdef TAG_LOOKUP_STATS_EN
      @(negedge TL_clk);
      n_cmp++;
      if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
         n_bad++;
         $display("FAIL stats_counts: hit=%0d miss=%0d, expected 3/2", hit_count, miss_count);
      end
      force dut.u_stats.hit_count = 16'hFFFF;
      @(negedge TL_clk);
      release dut.u_stats.hit_count;
      send_req(8'h08, rd, ok);
      get_resp(r);
      @(negedge TL_clk);
      n_cmp++;
      if (!r.hit || hit_count !== 16'hFFFF || miss_count !== 16'd2) begin
         n_bad++;
         $display("FAIL stats_saturate: hit=%h miss=%0d resp_hit=%0b, expected ffff/2/1",
                  hit_count, miss_count, r.hit);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_miss_after_reset();
      test_fill_hit();
      test_priority();
      test_timeout();
      test_reset_mid_op();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/tag_lookup_ctrl.md
TAG_LOOKUP_CTRL -- requirements
Module: tag_lookup_ctrl

Interface
REQ-001 Parameters: none; widths fixed: address 8 bits = tag[7:3] (5 bits) + index[2:0] (3 bits); tag word 6 bits = {valid[5], tag[4:0]}.
REQ-002 TL_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  lookup request qualifier.
REQ-005 req_addr  in  8  lookup address.
REQ-006 fill_valid  in  1  install request (line fill after miss).
REQ-007 fill_addr  in  8  address whose tag is installed valid.
REQ-008 req_ready  out  1  controller idle; accepts req_valid or fill_valid.
REQ-009 resp_valid  out  1  one-cycle lookup result pulse.
REQ-010 resp_hit  out  1  1 = hit, 0 = miss; meaningful only with resp_valid.
REQ-011 resp_err  out  1  array timeout; resp_hit forced 0.
REQ-012 ta_read_select  out  3  index to tag array.
REQ-013 ta_read_enable  out  1  tag array read strobe.
REQ-014 ta_finish  in  1  tag array read-complete pulse.
REQ-015 ta_out_data  in  6  tag array read data, valid while ta_finish=1.
REQ-016 ta_write_select / ta_write_data / ta_write_enable  out  3/6/1  tag array write port.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP, FILL; req_ready=1 only in IDLE.
REQ-018 IDLE: fill_valid=1 -> latch fill_addr, go FILL; else req_valid=1 -> latch req_addr, go ISSUE; fill has priority when both high, request stays pending.
REQ-019 ISSUE: ta_read_enable=1 for exactly one cycle, ta_read_select=latched index; next state WAIT.
REQ-020 WAIT: ta_read_enable=0; on ta_finish=1 latch ta_out_data, hit = data[5] & (data[4:0]==latched tag), go RESP.
REQ-021 Latency with zero-wait array: accept edge E0, array samples E1, finish sampled E2, resp_valid high E2..E3, IDLE again at E3.
REQ-022 WAIT timeout: 4-bit counter cleared in ISSUE, increments each WAIT cycle; on reaching 15 without ta_finish go RESP with resp_err=1, resp_hit=0.
REQ-023 ta_finish while not in WAIT is ignored.
REQ-024 RESP: resp_valid=1 one cycle, resp_hit/resp_err registered, then IDLE.
REQ-025 FILL: ta_write_enable=1 one cycle, ta_write_select=fill index, ta_write_data={1'b1, fill tag}; next state IDLE.
REQ-026 Fill followed by lookup of same index returns hit (array write completes at FILL edge before ISSUE read).
REQ-027 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst asserts asynchronously at any state, incl. mid-WAIT/FILL: state IDLE, all strobes 0, selects/data 0, resp_* 0, timeout counter 0, stats 0.
REQ-029 First request accepted at first rising edge after rst deasserts.

Configuration
REQ-030 TAG_LOOKUP_STATS_EN defined: outputs hit_count and miss_count (16 bits each), increment in RESP on hit / miss (timeout counts as miss), saturate at 16'hFFFF, cleared by rst.
REQ-031 TAG_LOOKUP_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-032 Shared package holds state enum, TAG_W=5, IDX_W=3, TAGWORD_W=6, TIMEOUT=15, and valid-bit position.
REQ-033 One sub-module natural: tag_lookup_stats (saturating hit/miss counters), instantiated only under TAG_LOOKUP_STATS_EN.

Verification
REQ-034 After reset, lookup 8'hA5 (tag 5'h14, idx 5) -> resp_valid at E2, resp_hit=0 (valid bits cleared).
REQ-035 Fill 8'hA5 then lookup 8'hA5 -> ta_write_data=6'h34 at idx 5, resp_hit=1; lookup 8'hAD (idx 5, tag 5'h15) -> resp_hit=0.
REQ-036 fill_valid and req_valid high same cycle -> FILL first, lookup served after, returns hit if same address.
REQ-037 Array model withholds ta_finish -> resp_valid with resp_err=1 after 15 WAIT cycles, then req_ready=1.
REQ-038 rst pulsed mid-WAIT -> outputs 0 immediately, IDLE; late ta_finish ignored, no resp_valid.
REQ-039 With TAG_LOOKUP_STATS_EN: 3 hits + 2 misses -> hit_count=3, miss_count=2; preload 16'hFFFF -> holds on further hits.
